// File: rtl/svm_pkg.sv
// Shared constants and types for the cardio SVM feature path.
package svm_pkg;

  localparam int N_FEAT  = 21;
  localparam int FEAT_W  = 4;
  localparam int FRAME_W = N_FEAT * FEAT_W;
  localparam int IDX_W   = $clog2(N_FEAT);
  localparam int CNT_W   = 16;

  // Loader states: FILL collects beats, PEND parks a complete frame in staging.
  typedef enum logic {
    FILL = 1'b0,
    PEND = 1'b1
  } state_t;

endpackage

// File: rtl/svm_frame_reg.sv
// Held output register for the assembled frame with valid/ready hold logic.
// A load always wins over a consume so back-to-back frames leave no bubble.
module svm_frame_reg
  import svm_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [FRAME_W-1:0] load_data,
  input  logic               m_ready,
  output logic               m_valid,
  output logic [FRAME_W-1:0] m_data
);

  // Output slot: load new frame, drop valid on consume, otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_data  <= '0;
    end else if (load) begin
      m_valid <= 1'b1;
      m_data  <= load_data;
    end else if (m_valid && m_ready) begin
      m_valid <= 1'b0;
    end else begin
      m_valid <= m_valid;
    end
  end

endmodule

// File: rtl/svm_feature_loader.sv
// Feature loader: assembles 21 x 4-bit features into one 84-bit frame,
// flags framing errors and hands complete frames to the output register.
module svm_feature_loader
  import svm_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [FEAT_W-1:0]  s_data,
  input  logic               s_last,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [FRAME_W-1:0] m_data,
  output logic               err_len,
  output logic [CNT_W-1:0]   frame_cnt
);

  state_t             state_r, state_s;
  logic [IDX_W-1:0]   idx_r, idx_s;
  logic [FRAME_W-1:0] staging_r, staging_s;
  logic [FRAME_W-1:0] frame_s, load_data_s;
  logic               ready_r, err_r, err_s;
  logic [CNT_W-1:0]   cnt_r;
  logic               beat_s, last_idx_s, slot_free_s, load_s;

  // Next-state, staging write, error detection and output-load decision.
  always_comb begin
    beat_s      = s_valid & ready_r;
    last_idx_s  = (idx_r == IDX_W'(N_FEAT - 1));
    slot_free_s = ~m_valid | m_ready;
    frame_s     = staging_r;
    frame_s[FEAT_W*(N_FEAT-1) +: FEAT_W] = s_data;
    state_s     = state_r;
    idx_s       = idx_r;
    staging_s   = staging_r;
    load_s      = 1'b0;
    load_data_s = frame_s;
    err_s       = 1'b0;
    case (state_r)
      FILL: begin
        if (beat_s) begin
          staging_s[FEAT_W*idx_r +: FEAT_W] = s_data;
          if (last_idx_s) begin
            // Frame complete; a missing s_last is flagged but the frame is kept.
            idx_s = '0;
            err_s = ~s_last;
            if (slot_free_s) begin
              load_s      = 1'b1;
              load_data_s = frame_s;
            end else begin
              state_s = PEND;
            end
          end else if (s_last) begin
            // Early end: drop the partial frame and resync.
            idx_s = '0;
            err_s = 1'b1;
          end else begin
            idx_s = idx_r + IDX_W'(1);
          end
        end else begin
          idx_s = idx_r;
        end
      end
      PEND: begin
        if (m_ready) begin
          load_s      = 1'b1;
          load_data_s = staging_r;
          state_s     = FILL;
        end else begin
          state_s = PEND;
        end
      end
      default: begin
        state_s = FILL;
        idx_s   = '0;
      end
    endcase
  end

  // State, index, staging, ready, error pulse and emitted-frame counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= FILL;
      idx_r     <= '0;
      staging_r <= '0;
      ready_r   <= 1'b0;
      err_r     <= 1'b0;
      cnt_r     <= '0;
    end else begin
      state_r   <= state_s;
      idx_r     <= idx_s;
      staging_r <= staging_s;
      ready_r   <= (state_s == FILL);
      err_r     <= err_s;
      if (load_s) begin
        cnt_r <= cnt_r + CNT_W'(1);
      end else begin
        cnt_r <= cnt_r;
      end
    end
  end

  svm_frame_reg u_frame_reg (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load_s),
    .load_data (load_data_s),
    .m_ready   (m_ready),
    .m_valid   (m_valid),
    .m_data    (m_data)
  );

  assign s_ready   = ready_r;
  assign err_len   = err_r;
  assign frame_cnt = cnt_r;

endmodule

// File: tb/tb_svm_feature_loader.sv
// Self-checking bench for svm_feature_loader: frame-level model in queues,
// a negedge compare process, and directed plus randomized scenarios.
module tb_svm_feature_loader;
  import svm_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [3:0]  s_data = 4'd0;
  logic        s_last = 1'b0;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [83:0] m_data;
  logic        err_len;
  logic [15:0] frame_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: features of the frame being collected, frames awaiting delivery, tallies.
  int          cur[$];
  logic [83:0] exp_q[$];
  int          completed = 0;
  int          exp_err   = 0;
  int          hs_count  = 0;
  int          err_seen  = 0;
  bit          rand_mr   = 1'b0;
  bit          gaps      = 1'b0;
  bit          prev_hold = 1'b0;
  logic [83:0] prev_data = '0;

  svm_feature_loader dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .s_last    (s_last),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .err_len   (err_len),
    .frame_cnt (frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [83:0] act, input logic [83:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Frame-level rule: 21 features make a frame; s_last earlier drops it.
  task automatic model_accept(input logic [3:0] d, input logic l);
    logic [83:0] f;
    cur.push_back(int'(d));
    if (cur.size() == N_FEAT) begin
      f = '0;
      for (int k = 0; k < N_FEAT; k++) f[4*k +: 4] = 4'(cur[k]);
      exp_q.push_back(f);
      completed++;
      if (!l) exp_err++;
      cur.delete();
    end else if (l) begin
      exp_err++;
      cur.delete();
    end
  endtask

  // One clock: drive at posedge+1, decide acceptance at negedge.
  task automatic cycle(input logic v, input logic [3:0] d, input logic l, output logic acc);
    s_valid = v;
    s_data  = d;
    s_last  = l;
    if (rand_mr) m_ready = 1'($urandom_range(0, 1));
    @(negedge clk);
    acc = v && s_ready;
    if (acc) model_accept(d, l);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    logic acc;
    for (int i = 0; i < n; i++) cycle(1'b0, 4'd0, 1'b0, acc);
  endtask

  task automatic send(input logic [3:0] d, input logic l);
    logic acc;
    int   tries;
    acc = 1'b0;
    tries = 0;
    while (!acc && tries < 500) begin
      cycle(1'b1, d, l, acc);
      tries++;
    end
    s_valid = 1'b0;
    if (!acc) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: beat not accepted after %0d cycles, required acceptance", tries);
    end
  endtask

  // mode 0: k%16, mode 1: 15-k%16, otherwise random values.
  task automatic send_frame(input int n, input bit mark_last, input int mode);
    logic [3:0] d;
    for (int k = 0; k < n; k++) begin
      if (mode == 0)      d = 4'(k % 16);
      else if (mode == 1) d = 4'(15 - (k % 16));
      else                d = 4'($urandom_range(0, 15));
      if (gaps && $urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
      send(d, mark_last && (k == n - 1));
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    s_valid = 1'b0;
    #1;
    check("rst_s_ready",   84'(s_ready),   84'(0));
    check("rst_m_valid",   84'(m_valid),   84'(0));
    check("rst_m_data",    m_data,         84'(0));
    check("rst_err_len",   84'(err_len),   84'(0));
    check("rst_frame_cnt", 84'(frame_cnt), 84'(0));
    cur.delete();
    exp_q.delete();
    completed = 0;
    exp_err   = 0;
    hs_count  = 0;
    err_seen  = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_s_ready", 84'(s_ready), 84'(1));
  endtask

  // Compare process: delivered frames, hold stability, error pulses, counter.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_hold = 1'b0;
      end else begin
        if (prev_hold) begin
          check("hold_valid", 84'(m_valid), 84'(1));
          check("hold_data",  m_data,       prev_data);
        end
        if (err_len) err_seen++;
        check("frame_cnt_loads", 84'(frame_cnt), 84'(16'(hs_count + (m_valid ? 1 : 0))));
        if (m_valid && m_ready) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_frame: got %0h expected no frame", m_data);
          end else begin
            check("frame_data", m_data, exp_q.pop_front());
          end
          hs_count++;
        end
        prev_hold = m_valid && !m_ready;
        prev_data = m_data;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int len;
    bit ml;
    #3;
    do_reset();

    // Test 1: ramp frame, latency and literal field positions.
    m_ready = 1'b1;
    send_frame(21, 1'b1, 0);
    check("t1_m_valid",   84'(m_valid),       84'(1));
    check("t1_feat0",     84'(m_data[3:0]),   84'(0));
    check("t1_feat20",    84'(m_data[83:80]), 84'(4));
    check("t1_feat7",     84'(m_data[31:28]), 84'(7));
    check("t1_frame_cnt", 84'(frame_cnt),     84'(1));
    idle(3);
    check("t1_err",       84'(err_seen),      84'(0));
    check("t1_hs",        84'(hs_count),      84'(1));
    check("t1_idle",      84'(m_valid),       84'(0));

    // Test 2: back-pressure, PEND, then two ordered handshakes.
    do_reset();
    m_ready = 1'b0;
    send_frame(21, 1'b1, 0);
    send_frame(21, 1'b1, 1);
    check("t2_pend_ready", 84'(s_ready),      84'(0));
    check("t2_held_valid", 84'(m_valid),      84'(1));
    check("t2_held_feat1", 84'(m_data[7:4]),  84'(1));
    check("t2_cnt_one",    84'(frame_cnt),    84'(1));
    idle(30);
    check("t2_still_pend", 84'(s_ready),      84'(0));
    m_ready = 1'b1;
    idle(4);
    check("t2_hs",         84'(hs_count),     84'(2));
    check("t2_frame_cnt",  84'(frame_cnt),    84'(2));
    check("t2_last_feat0", 84'(m_data[3:0]),  84'(15));
    check("t2_ready_back", 84'(s_ready),      84'(1));

    // Test 3: early s_last on beat 5, then a normal frame.
    do_reset();
    m_ready = 1'b1;
    send_frame(6, 1'b1, 2);
    idle(2);
    check("t3_err",     84'(err_seen), 84'(1));
    check("t3_novalid", 84'(m_valid),  84'(0));
    check("t3_hs0",     84'(hs_count), 84'(0));
    send_frame(21, 1'b1, 2);
    idle(2);
    check("t3_hs1",     84'(hs_count), 84'(1));
    check("t3_err1",    84'(err_seen), 84'(1));

    // Test 4: full frame without s_last is flagged but kept, index resyncs.
    do_reset();
    send_frame(21, 1'b0, 2);
    idle(2);
    check("t4_err", 84'(err_seen), 84'(1));
    check("t4_hs",  84'(hs_count), 84'(1));
    send_frame(21, 1'b1, 2);
    idle(2);
    check("t4_hs2",  84'(hs_count), 84'(2));
    check("t4_err2", 84'(err_seen), 84'(1));

    // Test 5: reset while PEND with a held frame.
    do_reset();
    m_ready = 1'b0;
    send_frame(21, 1'b1, 2);
    send_frame(21, 1'b1, 2);
    check("t5_pend_valid", 84'(m_valid), 84'(1));
    check("t5_pend_ready", 84'(s_ready), 84'(0));
    do_reset();
    m_ready = 1'b1;
    send_frame(21, 1'b1, 2);
    idle(2);
    check("t5_hs", 84'(hs_count), 84'(1));

    // Test 6: random data with input gaps, sink always ready.
    do_reset();
    gaps = 1'b1;
    for (int f = 0; f < 15; f++) send_frame(21, 1'b1, 2);
    idle(3);
    check("t6_hs",    84'(hs_count),     84'(15));
    check("t6_empty", 84'(exp_q.size()), 84'(0));

    // Test 7: random sink stalls, occasional truncated or unterminated frames.
    rand_mr = 1'b1;
    for (int f = 0; f < 20; f++) begin
      if ($urandom_range(0, 5) == 0) begin
        len = int'($urandom_range(1, 20));
        ml  = 1'b1;
      end else begin
        len = 21;
        ml  = ($urandom_range(0, 6) != 0);
      end
      send_frame(len, ml, 2);
    end
    rand_mr = 1'b0;
    gaps = 1'b0;
    m_ready = 1'b1;
    idle(5);
    check("t7_empty",     84'(exp_q.size()), 84'(0));
    check("t7_err",       84'(err_seen),     84'(exp_err));
    check("t7_hs",        84'(hs_count),     84'(completed));
    check("t7_frame_cnt", 84'(frame_cnt),    84'(16'(completed)));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
